// File: rtl/vx_bank_core_req_queue_pkg.sv
// Shared constants and helpers for the bank core-request queue.
// Parameter defaults live here so the top and the storage queue use one source.
package vx_bank_core_req_queue_pkg;

    localparam int DEF_NUM_REQUESTS = 4;
    localparam int DEF_WORD_SIZE    = 4;
    localparam int DEF_ADDR_WIDTH   = 30;
    localparam int DEF_TAG_WIDTH    = 8;
    localparam int DEF_CREQ_SIZE    = 4;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_bank_core_req_queue_generic_queue.sv
// Generic synchronous FIFO used as the entry store behind the head register.
// The caller never pushes when full or pops when empty.
module vx_bank_core_req_queue_generic_queue
    import vx_bank_core_req_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty
);
    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array: written on push, never reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/vx_bank_core_req_queue.sv
// Bank core-request queue: buffers multi-lane request vectors and presents
// them one lane at a time (lowest lane first) through a head register.
module vx_bank_core_req_queue
    import vx_bank_core_req_queue_pkg::*;
#(
    parameter  int NUM_REQUESTS = DEF_NUM_REQUESTS,
    parameter  int WORD_SIZE    = DEF_WORD_SIZE,
    parameter  int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter  int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter  int CREQ_SIZE    = DEF_CREQ_SIZE,
    localparam int TID_W        = idx_width(NUM_REQUESTS)
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [NUM_REQUESTS-1:0]             req_valids,
    input  logic [NUM_REQUESTS-1:0]             req_rw,
    input  logic [NUM_REQUESTS*WORD_SIZE-1:0]   req_byteen,
    input  logic [NUM_REQUESTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQUESTS*WORD_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]                req_tag,
    input  logic                                pop,
    output logic                                out_valid,
    output logic [TID_W-1:0]                    out_tid,
    output logic                                out_rw,
    output logic [WORD_SIZE-1:0]                out_byteen,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic [WORD_SIZE*8-1:0]              out_data,
    output logic [TAG_WIDTH-1:0]                out_tag,
    output logic                                full,
    output logic                                empty
);
    localparam int N       = NUM_REQUESTS;
    localparam int DATA_W  = WORD_SIZE * 8;
    localparam int CNT_W   = $clog2(CREQ_SIZE + 1);
    localparam int ENTRY_W = N * (1 + 1 + WORD_SIZE + ADDR_WIDTH + DATA_W) + TAG_WIDTH;
    // Entry layout, LSB first: tag, data, addr, byteen, rw, valids.
    localparam int OFF_DATA = TAG_WIDTH;
    localparam int OFF_ADDR = OFF_DATA + N * DATA_W;
    localparam int OFF_BE   = OFF_ADDR + N * ADDR_WIDTH;
    localparam int OFF_RW   = OFF_BE + N * WORD_SIZE;
    localparam int OFF_VAL  = OFF_RW + N;

    // Lowest set lane of the remaining mask.
    function automatic logic [TID_W-1:0] lowest_lane(input logic [N-1:0] m);
        lowest_lane = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = TID_W'(i);
        end
    endfunction

    logic [N-1:0]             r_mask;
    logic [N-1:0]             r_head_rw;
    logic [N*WORD_SIZE-1:0]   r_head_byteen;
    logic [N*ADDR_WIDTH-1:0]  r_head_addr;
    logic [N*DATA_W-1:0]      r_head_data;
    logic [TAG_WIDTH-1:0]     r_head_tag;
    logic [CNT_W-1:0]         r_count;
    logic                     r_full;
    logic                     r_empty;

    logic [ENTRY_W-1:0]       w_push_entry;
    logic [ENTRY_W-1:0]       w_fifo_entry;
    logic [ENTRY_W-1:0]       w_load_entry;
    logic [TID_W-1:0]         w_tid;
    logic [N-1:0]             w_remaining;
    logic                     w_pop_fire;
    logic                     w_last_pop;
    logic                     w_head_free;
    logic                     w_push_acc;
    logic                     w_fifo_empty;
    logic                     w_head_from_push;
    logic                     w_fifo_push;
    logic                     w_fifo_pop;
    logic                     w_head_load;
    logic [CNT_W-1:0]         w_count_next;

    assign w_push_entry = {req_valids, req_rw, req_byteen, req_addr, req_data, req_tag};

    // Lane selection and handshake decode.
    assign w_tid       = lowest_lane(r_mask);
    assign w_remaining = r_mask & ~(N'(1) << w_tid);
    assign out_valid   = (r_mask != '0);
    assign w_pop_fire  = pop && out_valid;
    assign w_last_pop  = w_pop_fire && (w_remaining == '0);
    assign w_head_free = !out_valid || w_last_pop;

    // A push is gated by the registered full flag only; a simultaneous
    // last-lane pop does not open a slot in the same cycle.
    assign w_push_acc       = push && !r_full && (req_valids != '0);
    assign w_head_from_push = w_push_acc && w_head_free && w_fifo_empty;
    assign w_fifo_push      = w_push_acc && !w_head_from_push;
    assign w_fifo_pop       = w_head_free && !w_fifo_empty;
    assign w_head_load      = w_head_from_push || w_fifo_pop;
    assign w_load_entry     = w_head_from_push ? w_push_entry : w_fifo_entry;

    vx_bank_core_req_queue_generic_queue #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (CREQ_SIZE - 1)
    ) u_entry_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_data  (w_push_entry),
        .o_data  (w_fifo_entry),
        .o_empty (w_fifo_empty)
    );

    // Head lane mask: reload on entry load, otherwise retire the popped lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_head_load) begin
            r_mask <= w_load_entry[OFF_VAL +: N];
        end else if (w_pop_fire) begin
            r_mask <= w_remaining;
        end
    end

    // Head payload: loaded with the mask, left unreset.
    always_ff @(posedge clk) begin
        if (w_head_load) begin
            r_head_rw     <= w_load_entry[OFF_RW   +: N];
            r_head_byteen <= w_load_entry[OFF_BE   +: N * WORD_SIZE];
            r_head_addr   <= w_load_entry[OFF_ADDR +: N * ADDR_WIDTH];
            r_head_data   <= w_load_entry[OFF_DATA +: N * DATA_W];
            r_head_tag    <= w_load_entry[0        +: TAG_WIDTH];
        end
    end

    // Next entry count: +1 on accepted push, -1 on last-lane pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push_acc, w_last_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Entry counter with registered full/empty flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(CREQ_SIZE));
            r_empty <= (w_count_next == '0);
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign out_tid    = w_tid;
    assign out_rw     = r_head_rw[w_tid];
    assign out_byteen = r_head_byteen[w_tid * WORD_SIZE +: WORD_SIZE];
    assign out_addr   = r_head_addr[w_tid * ADDR_WIDTH +: ADDR_WIDTH];
    assign out_data   = r_head_data[w_tid * DATA_W +: DATA_W];
    assign out_tag    = r_head_tag;

endmodule

// File: tb/tb_vx_bank_core_req_queue.sv
// Testbench for vx_bank_core_req_queue: directed scenarios plus a randomized
// run checked against an entry-level queue model.
module tb_vx_bank_core_req_queue;

    localparam int N     = 4;
    localparam int WS    = 4;
    localparam int AW    = 30;
    localparam int TW    = 8;
    localparam int CREQ  = 4;
    localparam int TID_W = 2;
    localparam int DW    = WS * 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              push = 1'b0;
    logic [N-1:0]      req_valids = '0;
    logic [N-1:0]      req_rw = '0;
    logic [N*WS-1:0]   req_byteen = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [TW-1:0]     req_tag = '0;
    logic              pop = 1'b0;
    logic              out_valid;
    logic [TID_W-1:0]  out_tid;
    logic              out_rw;
    logic [WS-1:0]     out_byteen;
    logic [AW-1:0]     out_addr;
    logic [DW-1:0]     out_data;
    logic [TW-1:0]     out_tag;
    logic              full;
    logic              empty;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [N-1:0]    mask;
        logic [N-1:0]    rw;
        logic [N*WS-1:0] be;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] data;
        logic [TW-1:0]   tag;
    } ent_t;

    ent_t mq[$];

    vx_bank_core_req_queue #(
        .NUM_REQUESTS (N),
        .WORD_SIZE    (WS),
        .ADDR_WIDTH   (AW),
        .TAG_WIDTH    (TW),
        .CREQ_SIZE    (CREQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .req_valids (req_valids),
        .req_rw     (req_rw),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .pop        (pop),
        .out_valid  (out_valid),
        .out_tid    (out_tid),
        .out_rw     (out_rw),
        .out_byteen (out_byteen),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic int low_lane(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // Entry-level reference: a list of entries, each with its remaining lanes.
    task automatic model_edge();
        ent_t h;
        ent_t e;
        bit   acc;
        if (reset) begin
            mq.delete();
        end else begin
            acc = push && (mq.size() < CREQ) && (req_valids != '0);
            if (pop && mq.size() > 0) begin
                h = mq[0];
                h.mask[low_lane(h.mask)] = 1'b0;
                if (h.mask == '0) void'(mq.pop_front());
                else mq[0] = h;
            end
            if (acc) begin
                e.mask = req_valids;
                e.rw   = req_rw;
                e.be   = req_byteen;
                e.addr = req_addr;
                e.data = req_data;
                e.tag  = req_tag;
                mq.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic randomize_lanes();
        logic [127:0] a;
        a          = {$urandom, $urandom, $urandom, $urandom};
        req_addr   = a[N*AW-1:0];
        req_data   = {$urandom, $urandom, $urandom, $urandom};
        req_rw     = N'($urandom);
        req_byteen = (N*WS)'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        vectors++;
        if ({out_valid, empty, full} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_state valid/empty/full got %b want 010", {out_valid, empty, full});
        end
    endtask

    task automatic test_lane_drain();
        int           exp_tids[3] = '{0, 1, 3};
        logic [N*AW-1:0] a;
        randomize_lanes();
        a = req_addr;
        push = 1'b1; req_valids = 4'b1011; req_tag = 8'h5A; pop = 1'b1;
        cycle();
        push = 1'b0; req_valids = '0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({out_valid, empty, out_tid, out_tag, out_addr} !==
                {1'b1, 1'b0, TID_W'(exp_tids[k]), 8'h5A, a[exp_tids[k]*AW +: AW]}) begin
                miscompares++;
                $display("FAIL drain_lane%0d valid=%b empty=%b tid=%0d tag=%h addr=%h want tid=%0d tag=5a addr=%h",
                         k, out_valid, empty, out_tid, out_tag, out_addr, exp_tids[k], a[exp_tids[k]*AW +: AW]);
            end
            cycle();
        end
        vectors++;
        if ({out_valid, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL drain_end valid/empty got %b want 01", {out_valid, empty});
        end
        pop = 1'b0;
    endtask

    task automatic test_fill_full();
        pop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            randomize_lanes();
            push = 1'b1; req_valids = 4'b0001; req_tag = TW'(k + 1);
            cycle();
        end
        push = 1'b0;
        vectors++;
        if ({full, empty} !== 2'b10) begin
            miscompares++;
            $display("FAIL fill_full full/empty got %b want 10", {full, empty});
        end
        push = 1'b1; req_valids = 4'b0001; req_tag = 8'h05;
        cycle();
        push = 1'b0;
        vectors++;
        if ({full, out_tag} !== {1'b1, 8'h01}) begin
            miscompares++;
            $display("FAIL fill_overflow full=%b tag=%h want full=1 tag=01", full, out_tag);
        end
        pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({out_valid, out_tag} !== {1'b1, TW'(k + 1)}) begin
                miscompares++;
                $display("FAIL fill_drain%0d valid=%b tag=%h want tag=%h", k, out_valid, out_tag, k + 1);
            end
            cycle();
        end
        vectors++;
        if ({out_valid, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL fill_dropped valid/empty got %b want 01", {out_valid, empty});
        end
        pop = 1'b0;
    endtask

    task automatic test_full_pop_push();
        pop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            randomize_lanes();
            push = 1'b1; req_valids = 4'b0001; req_tag = TW'(8'h10 + k);
            cycle();
        end
        push = 1'b1; req_valids = 4'b0001; req_tag = 8'hEE; pop = 1'b1;
        cycle();
        push = 1'b0;
        vectors++;
        if ({full, empty, out_valid, out_tag} !== {1'b0, 1'b0, 1'b1, 8'h11}) begin
            miscompares++;
            $display("FAIL fullpop full=%b empty=%b valid=%b tag=%h want 0 0 1 11", full, empty, out_valid, out_tag);
        end
        for (int k = 1; k < 4; k++) begin
            vectors++;
            if ({out_valid, out_tag} !== {1'b1, TW'(8'h10 + k)}) begin
                miscompares++;
                $display("FAIL fullpop_drain%0d valid=%b tag=%h want %h", k, out_valid, out_tag, 8'h10 + k);
            end
            cycle();
        end
        vectors++;
        if ({out_valid, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL fullpop_rejected valid/empty got %b want 01", {out_valid, empty});
        end
        pop = 1'b0;
    endtask

    task automatic test_back_to_back();
        randomize_lanes();
        push = 1'b1; req_valids = 4'b0001; req_tag = 8'hA1; pop = 1'b1;
        cycle();
        vectors++;
        if ({out_valid, out_tid, out_tag} !== {1'b1, 2'd0, 8'hA1}) begin
            miscompares++;
            $display("FAIL b2b_first valid=%b tid=%0d tag=%h want 1 0 a1", out_valid, out_tid, out_tag);
        end
        req_valids = 4'b0100; req_tag = 8'hA2;
        cycle();
        push = 1'b0;
        vectors++;
        if ({out_valid, out_tid, out_tag} !== {1'b1, 2'd2, 8'hA2}) begin
            miscompares++;
            $display("FAIL b2b_second valid=%b tid=%0d tag=%h want 1 2 a2", out_valid, out_tid, out_tag);
        end
        cycle();
        pop = 1'b0;
        // Same pair queued first, then drained from the FIFO.
        push = 1'b1; req_valids = 4'b0001; req_tag = 8'hB1;
        cycle();
        req_valids = 4'b0100; req_tag = 8'hB2;
        cycle();
        push = 1'b0; pop = 1'b1;
        vectors++;
        if ({out_valid, out_tid, out_tag} !== {1'b1, 2'd0, 8'hB1}) begin
            miscompares++;
            $display("FAIL b2b_q_first valid=%b tid=%0d tag=%h want 1 0 b1", out_valid, out_tid, out_tag);
        end
        cycle();
        vectors++;
        if ({out_valid, out_tid, out_tag} !== {1'b1, 2'd2, 8'hB2}) begin
            miscompares++;
            $display("FAIL b2b_q_second valid=%b tid=%0d tag=%h want 1 2 b2", out_valid, out_tid, out_tag);
        end
        cycle();
        pop = 1'b0;
        vectors++;
        if ({out_valid, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_end valid/empty got %b want 01", {out_valid, empty});
        end
    endtask

    task automatic test_zero_valids();
        push = 1'b1; req_valids = '0; req_tag = 8'h33;
        cycle();
        cycle();
        push = 1'b0;
        vectors++;
        if ({out_valid, empty, full} !== 3'b010) begin
            miscompares++;
            $display("FAIL zero_valids valid/empty/full got %b want 010", {out_valid, empty, full});
        end
    endtask

    task automatic test_reset_mid();
        pop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            randomize_lanes();
            push = 1'b1; req_valids = 4'b0001; req_tag = TW'(8'h40 + k);
            cycle();
        end
        vectors++;
        if ({empty, full} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_held empty/full got %b want 00", {empty, full});
        end
        reset = 1'b1; push = 1'b1; req_valids = 4'b1111; pop = 1'b1;
        cycle();
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        vectors++;
        if ({out_valid, empty, full} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstmid_cleared valid/empty/full got %b want 010", {out_valid, empty, full});
        end
        push = 1'b1; req_valids = 4'b0010; req_tag = 8'h77;
        cycle();
        push = 1'b0;
        vectors++;
        if ({out_valid, out_tid, out_tag} !== {1'b1, 2'd1, 8'h77}) begin
            miscompares++;
            $display("FAIL rstmid_push valid=%b tid=%0d tag=%h want 1 1 77", out_valid, out_tid, out_tag);
        end
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        vectors++;
        if ({out_valid, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_end valid/empty got %b want 01", {out_valid, empty});
        end
    endtask

    task automatic test_random();
        ent_t e;
        int   t;
        bit   ev;
        int   pop_pct;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            pop_pct    = (i < 300) ? 30 : 70;
            push       = ($urandom_range(99, 0) < 60);
            req_valids = ($urandom_range(9, 0) == 0) ? '0 : N'($urandom);
            randomize_lanes();
            req_tag    = TW'($urandom);
            pop        = ($urandom_range(99, 0) < pop_pct);
            cycle();
            ev = (mq.size() > 0);
            vectors++;
            if ({out_valid, empty, full} !== {ev, mq.size() == 0, mq.size() == CREQ}) begin
                miscompares++;
                $display("FAIL rand_status cyc %0d valid/empty/full got %b want %b", i,
                         {out_valid, empty, full}, {ev, mq.size() == 0, mq.size() == CREQ});
            end
            if (ev) begin
                e = mq[0];
                t = low_lane(e.mask);
                vectors++;
                if ({out_tid, out_rw, out_byteen, out_addr, out_data, out_tag} !==
                    {TID_W'(t), e.rw[t], e.be[t*WS +: WS], e.addr[t*AW +: AW], e.data[t*DW +: DW], e.tag}) begin
                    miscompares++;
                    $display("FAIL rand_lane cyc %0d tid=%0d rw=%b be=%h addr=%h data=%h tag=%h want tid=%0d rw=%b be=%h addr=%h data=%h tag=%h",
                             i, out_tid, out_rw, out_byteen, out_addr, out_data, out_tag,
                             t, e.rw[t], e.be[t*WS +: WS], e.addr[t*AW +: AW], e.data[t*DW +: DW], e.tag);
                end
            end
        end
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lane_drain();
        test_fill_full();
        test_full_pop_push();
        test_back_to_back();
        test_zero_valids();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
